// File: rtl/vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_sequencer
// Purpose  : Walks the eight {B,C,D} input vectors through a downstream stage,
//            holds each for HOLD_CYCLES, then checks Y_in against D&(B|~C).
// Revision : 1.0  initial release
// ============================================================================
module vector_sequencer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       Y_in,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    localparam logic [3:0] c_hold_last = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_idx;
    logic [3:0] r_hold;
    logic       r_b;
    logic       r_c;
    logic       r_d;
    logic       r_pass;
    logic [3:0] r_err;
    logic [7:0] r_fail;
    logic       w_exp;
    logic       w_mismatch;
    logic [3:0] w_err_next;
    logic       w_busy;
    logic       w_done;

    // Expected response is taken from the registered vector, not from r_idx.
    assign w_exp      = r_d & (r_b | ~r_c);
    assign w_mismatch = (r_state == S_CHECK) && (Y_in != w_exp);
    assign w_err_next = r_err + {3'b000, w_mismatch};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_APPLY;
            end
            S_APPLY: begin
                w_busy = 1'b1;
                if (r_hold == c_hold_last) w_next = S_CHECK;
            end
            S_CHECK: begin
                w_busy = 1'b1;
                w_next = (r_idx == 3'd7) ? S_DONE : S_APPLY;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (start) w_next = S_APPLY;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= 3'd0;
            r_hold <= 4'd0;
            r_b    <= 1'b0;
            r_c    <= 1'b0;
            r_d    <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= 4'd0;
            r_fail <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_idx  <= 3'd0;
                        r_hold <= 4'd0;
                        r_b    <= 1'b0;
                        r_c    <= 1'b0;
                        r_d    <= 1'b0;
                        r_pass <= 1'b0;
                        r_err  <= 4'd0;
                        r_fail <= 8'd0;
                    end
                end
                S_APPLY: begin
                    r_hold <= r_hold + 4'd1;
                end
                S_CHECK: begin
                    r_err <= w_err_next;
                    if (w_mismatch) r_fail[r_idx] <= 1'b1;
                    if (r_idx == 3'd7) begin
                        // Final verdict must include the result of this last check.
                        r_pass <= (w_err_next == 4'd0);
                    end else begin
                        r_idx             <= r_idx + 3'd1;
                        r_hold            <= 4'd0;
                        {r_b, r_c, r_d}   <= r_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign B         = r_b;
    assign C         = r_c;
    assign D         = r_d;
    assign busy      = w_busy;
    assign done      = w_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_sequencer
// Purpose  : Directed self-checking bench for vector_sequencer (HOLD 2 and 1).
// Revision : 1.0  initial release
// ============================================================================
module tb_vector_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic       Y_in0, Y_in1;
    logic       B0, C0, D0, busy0, done0, pass0;
    logic       B1, C1, D1, busy1, done1, pass1;
    logic [3:0] err0, err1;
    logic [7:0] fail0, fail1;
    int         mode0, mode1;   // 0 correct stage, 1 stuck-at-0, 2 stuck-at-1
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc;

    always #5 clk = ~clk;

    assign Y_in0 = (mode0 == 0) ? (D0 & (B0 | ~C0)) : (mode0 == 2);
    assign Y_in1 = (mode1 == 0) ? (D1 & (B1 | ~C1)) : (mode1 == 2);

    vector_sequencer #(.HOLD_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start0), .Y_in(Y_in0),
        .B(B0), .C(C0), .D(D0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fail0)
    );

    vector_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .Y_in(Y_in1),
        .B(B1), .C(C1), .D(D1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fail1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Pulse start, then count edges until done; extra start pulses at pa/pb.
    task automatic run0(input int m, input int pa, input int pb, output int cycles);
        @(negedge clk);
        mode0  = m;
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        check("accept_flags", {busy0, done0, pass0}, 3'b100);
        check("accept_clear", {err0, fail0, B0, C0, D0}, 15'd0);
        cycles = 0;
        while (!done0 && cycles < 100) begin
            @(posedge clk);
            #1 cycles++;
            start0 = (cycles == pa) || (cycles == pb);
            if (cycles == 4) check("vec1_bcd", {B0, C0, D0}, 3'd1);
        end
        start0 = 1'b0;
    endtask

    task automatic run1(input int m, output int cycles);
        @(negedge clk);
        mode1  = m;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        check("h1_accept_clear", {err1, fail1}, 12'd0);
        cycles = 0;
        while (!done1 && cycles < 100) begin
            @(posedge clk);
            #1 cycles++;
        end
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode0 = 0; mode1 = 0;
        repeat (3) @(posedge clk);
        #1 check("reset_state", {busy0, done0, pass0, err0, fail0, B0, C0, D0}, 18'd0);
        @(negedge clk) rst = 1'b0;

        // Correct stage
        run0(0, 0, 0, cyc);
        check("good_cycles", cyc, 24);
        check("good_result", {busy0, done0, pass0, err0, fail0}, {3'b011, 4'd0, 8'h00});
        check("good_last_vec", {B0, C0, D0}, 3'd7);

        // Stuck-at-0
        run0(1, 0, 0, cyc);
        check("sa0_cycles", cyc, 24);
        check("sa0_result", {pass0, err0, fail0}, {1'b0, 4'd3, 8'hA2});
        repeat (3) @(posedge clk);
        #1 check("done_hold", {done0, busy0, err0, fail0, B0, C0, D0}, {2'b10, 4'd3, 8'hA2, 3'd7});

        // Restart from DONE with a correct stage
        run0(0, 0, 0, cyc);
        check("restart_cycles", cyc, 24);
        check("restart_result", {pass0, err0, fail0}, {1'b1, 4'd0, 8'h00});

        // Stuck-at-1
        run0(2, 0, 0, cyc);
        check("sa1_result", {pass0, err0, fail0}, {1'b0, 4'd5, 8'h5D});

        // Start pulses during a run are ignored
        run0(1, 5, 12, cyc);
        check("busy_start_cycles", cyc, 24);
        check("busy_start_result", {pass0, err0, fail0}, {1'b0, 4'd3, 8'hA2});

        // Mid-run reset
        @(negedge clk);
        mode0 = 2; start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 check("midrun_reset", {busy0, done0, pass0, err0, fail0, B0, C0, D0}, 18'd0);
        @(negedge clk) rst = 1'b0;
        run0(0, 0, 0, cyc);
        check("post_reset_run", {cyc[7:0], pass0, err0}, {8'd24, 1'b1, 4'd0});

        // Start held high: one run, then immediate restart after DONE
        @(negedge clk);
        mode0 = 0; start0 = 1'b1;
        @(posedge clk);
        cyc = 0;
        #1;
        while (!done0 && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("held_start_cycles", cyc, 24);
        @(posedge clk);
        #1 check("held_start_restart", {busy0, done0, err0, B0, C0, D0}, {2'b10, 4'd0, 3'd0});
        @(negedge clk) begin start0 = 1'b0; rst = 1'b1; end
        @(negedge clk) rst = 1'b0;

        // HOLD_CYCLES=1 instance: stuck-at-0 then restart with a correct stage
        run1(1, cyc);
        check("h1_sa0", {cyc[7:0], pass1, err1, fail1}, {8'd16, 1'b0, 4'd3, 8'hA2});
        run1(0, cyc);
        check("h1_good", {cyc[7:0], pass1, err1, fail1}, {8'd16, 1'b1, 4'd0, 8'h00});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
